// File: rtl/rgb_to_colour.sv
// rtl/rgb_to_colour.sv - nearest 8-colour palette search, one entry per clock
// Optional build macro: EARLY_EXIT_EN (stop searching on an exact match)
module rgb_to_colour #(
  parameter int TOL = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [23:0] rgb_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [2:0]  colour_out,
  output logic [9:0]  dist_out,
  output logic        exact_out
);

  typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_t;

  localparam logic [9:0] TOL_V = 10'(TOL);

  state_t      state;
  logic [23:0] rgb_q;
  logic [2:0]  idx;
  logic [2:0]  best_idx;
  logic [9:0]  best_dist;

  logic [23:0] pal;
  logic [7:0]  ad_r, ad_g, ad_b;
  logic [9:0]  cand_dist;
  logic        cand_better;
  logic [2:0]  next_idx;
  logic [9:0]  next_dist;
  logic        hit;

  function automatic logic [7:0] absdiff(input logic [7:0] a, input logic [7:0] b);
    return (a > b) ? (a - b) : (b - a);
  endfunction

  // Palette entry is each index bit replicated across its 8-bit channel.
  always_comb begin
    pal         = {{8{idx[2]}}, {8{idx[1]}}, {8{idx[0]}}};
    ad_r        = absdiff(rgb_q[23:16], pal[23:16]);
    ad_g        = absdiff(rgb_q[15:8],  pal[15:8]);
    ad_b        = absdiff(rgb_q[7:0],   pal[7:0]);
    cand_dist   = {2'b00, ad_r} + {2'b00, ad_g} + {2'b00, ad_b};
    cand_better = (cand_dist < best_dist);
    next_idx    = cand_better ? idx : best_idx;
    next_dist   = cand_better ? cand_dist : best_dist;
`ifdef EARLY_EXIT_EN
    hit         = (cand_dist == 10'd0);
`else
    hit         = 1'b0;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      rgb_q      <= 24'd0;
      idx        <= 3'd0;
      best_idx   <= 3'd0;
      best_dist  <= 10'd0;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      colour_out <= 3'd0;
      dist_out   <= 10'd0;
      exact_out  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            rgb_q     <= rgb_in;
            idx       <= 3'd0;
            best_dist <= 10'h3FF;
            best_idx  <= 3'd0;
            in_ready  <= 1'b0;
            state     <= SEARCH;
          end
        end
        SEARCH: begin
          best_idx  <= next_idx;
          best_dist <= next_dist;
          idx       <= idx + 3'd1;
          if (idx == 3'd7 || hit) begin
            colour_out <= next_idx;
            dist_out   <= next_dist;
            exact_out  <= (next_dist <= TOL_V);
            out_valid  <= 1'b1;
            state      <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rgb_to_colour.sv
// tb/tb_rgb_to_colour.sv - directed bench for rgb_to_colour (default and TOL=160)
module tb_rgb_to_colour;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [23:0] rgb_in = 24'd0;
  logic        out_ready = 1'b0;

  logic        in_ready, out_valid, exact_out;
  logic [2:0]  colour_out;
  logic [9:0]  dist_out;
  logic        t_in_ready, t_out_valid, t_exact_out;
  logic [2:0]  t_colour_out;
  logic [9:0]  t_dist_out;

  int total = 0;
  int bad   = 0;

`ifdef EARLY_EXIT_EN
  localparam int LAT_GREEN = 3;
  localparam int LAT_BLACK = 1;
`else
  localparam int LAT_GREEN = 8;
  localparam int LAT_BLACK = 8;
`endif

  always #5 clk = ~clk;

  rgb_to_colour dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .rgb_in(rgb_in),
    .out_valid(out_valid), .out_ready(out_ready), .colour_out(colour_out),
    .dist_out(dist_out), .exact_out(exact_out)
  );

  // Driven in lock-step with dut; only the tolerance differs.
  rgb_to_colour #(.TOL(160)) dut_t (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(t_in_ready), .rgb_in(rgb_in),
    .out_valid(t_out_valid), .out_ready(out_ready), .colour_out(t_colour_out),
    .dist_out(t_dist_out), .exact_out(t_exact_out)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present rgb and return once the accept edge has passed.
  task automatic send(input logic [23:0] rgb, output bit timeout);
    int n = 0;
    in_valid = 1'b1;
    rgb_in   = rgb;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    timeout = !in_ready;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int cycles);
    cycles = 0;
    while (!out_valid && cycles < 50) begin
      tick();
      cycles++;
    end
  endtask

  task automatic take();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || colour_out !== 3'd0 ||
        dist_out !== 10'd0 || exact_out !== 1'b0) begin
      bad++;
      $display("FAIL reset_state: rdy=%b val=%b col=%0d dist=%0d ex=%b, want 1 0 0 0 0",
               in_ready, out_valid, colour_out, dist_out, exact_out);
    end
  endtask

  task automatic test_exact_green();
    bit to; int cyc;
    send(24'h00FF00, to);
    wait_out(cyc);
    total++;
    if (to || cyc !== LAT_GREEN) begin
      bad++;
      $display("FAIL green_latency: got %0d (timeout=%0b), want %0d", cyc, to, LAT_GREEN);
    end
    total++;
    if (colour_out !== 3'b010 || dist_out !== 10'd0 || exact_out !== 1'b1) begin
      bad++;
      $display("FAIL green_result: col=%0d dist=%0d ex=%b, want 2 0 1", colour_out, dist_out, exact_out);
    end
    take();
  endtask

  task automatic test_nearest();
    bit to; int cyc;
    send(24'h8010F0, to);
    wait_out(cyc);
    total++;
    if (to || cyc !== 8) begin
      bad++;
      $display("FAIL nearest_latency: got %0d, want 8", cyc);
    end
    total++;
    if (colour_out !== 3'b101 || dist_out !== 10'd158 || exact_out !== 1'b0) begin
      bad++;
      $display("FAIL nearest_result: col=%0d dist=%0d ex=%b, want 5 158 0", colour_out, dist_out, exact_out);
    end
    take();
  endtask

  task automatic test_reset_mid_search();
    bit to; int cyc;
    send(24'h0000FF, to);
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || colour_out !== 3'd0 || dist_out !== 10'd0) begin
      bad++;
      $display("FAIL reset_mid: val=%b rdy=%b col=%0d dist=%0d, want 0 1 0 0",
               out_valid, in_ready, colour_out, dist_out);
    end
    tick();
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_hold: val=%b rdy=%b, want 0 1", out_valid, in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    send(24'hFF00FF, to);
    wait_out(cyc);
    total++;
    if (to || colour_out !== 3'b101 || dist_out !== 10'd0 || exact_out !== 1'b1) begin
      bad++;
      $display("FAIL after_reset: col=%0d dist=%0d ex=%b, want 5 0 1", colour_out, dist_out, exact_out);
    end
    take();
  endtask

  task automatic test_backpressure();
    bit to; int cyc; bit stable = 1'b1;
    send(24'h8010F0, to);
    wait_out(cyc);
    for (int i = 0; i < 5; i++) begin
      in_valid = ~in_valid;
      rgb_in   = 24'h123456 + 24'(i * 24'h010101);
      tick();
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || colour_out !== 3'b101 ||
          dist_out !== 10'd158 || exact_out !== 1'b0) stable = 1'b0;
    end
    total++;
    if (!stable) begin
      bad++;
      $display("FAIL stall_stable: val=%b rdy=%b col=%0d dist=%0d, want 1 0 5 158",
               out_valid, in_ready, colour_out, dist_out);
    end
    in_valid = 1'b0;
    take();
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL stall_release: val=%b rdy=%b, want 0 1", out_valid, in_ready);
    end
    tick();
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL single_handshake: val=%b rdy=%b, want 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    rgb_in    = 24'hFFFFFF;
    tick();
    rgb_in    = 24'h000000;
    wait_out(cyc);
    total++;
    if (cyc !== 8 || colour_out !== 3'b111 || dist_out !== 10'd0) begin
      bad++;
      $display("FAIL b2b_first: cyc=%0d col=%0d dist=%0d, want 8 7 0", cyc, colour_out, dist_out);
    end
    tick();
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL b2b_gap: val=%b rdy=%b, want 0 1", out_valid, in_ready);
    end
    tick();
    in_valid = 1'b0;
    total++;
    if (in_ready !== 1'b0) begin
      bad++;
      $display("FAIL b2b_second_accept: rdy=%b, want 0", in_ready);
    end
    out_ready = 1'b0;
    wait_out(cyc);
    total++;
    if (cyc !== LAT_BLACK || colour_out !== 3'b000 || dist_out !== 10'd0 || exact_out !== 1'b1) begin
      bad++;
      $display("FAIL b2b_second: cyc=%0d col=%0d dist=%0d ex=%b, want %0d 0 0 1",
               cyc, colour_out, dist_out, exact_out, LAT_BLACK);
    end
    take();
  endtask

  task automatic test_tol();
    bit to; int cyc;
    send(24'h8010F0, to);
    wait_out(cyc);
    total++;
    if (t_out_valid !== 1'b1 || t_colour_out !== 3'b101 || t_dist_out !== 10'd158 || t_exact_out !== 1'b1) begin
      bad++;
      $display("FAIL tol_near: val=%b col=%0d dist=%0d ex=%b, want 1 5 158 1",
               t_out_valid, t_colour_out, t_dist_out, t_exact_out);
    end
    take();
    send(24'h808080, to);
    wait_out(cyc);
    total++;
    if (t_out_valid !== 1'b1 || t_colour_out !== 3'b111 || t_dist_out !== 10'd381 || t_exact_out !== 1'b0) begin
      bad++;
      $display("FAIL tol_far: val=%b col=%0d dist=%0d ex=%b, want 1 7 381 0",
               t_out_valid, t_colour_out, t_dist_out, t_exact_out);
    end
    total++;
    if (colour_out !== 3'b111 || dist_out !== 10'd381 || exact_out !== 1'b0) begin
      bad++;
      $display("FAIL grey_default: col=%0d dist=%0d ex=%b, want 7 381 0", colour_out, dist_out, exact_out);
    end
    take();
  endtask

  initial begin
    #12;
    test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    test_reset();
    test_exact_green();
    test_nearest();
    test_reset_mid_search();
    test_backpressure();
    test_back_to_back();
    test_tol();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
